// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with sweep-level debounce.
// Drives one column low at a time, snapshots all 16 switches once per sweep and
// accepts a key only after DEBOUNCE_SCANS identical single-key sweeps. A release is
// accepted after DEBOUNCE_SCANS empty sweeps. Outputs are one-hot row/column, a
// 4-bit key code and one-cycle press/release strobes.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 20000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] row_n_i,
  output logic [3:0] col_n_o,
  output logic [3:0] key_row_o,
  output logic [3:0] key_col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_press_o,
  output logic       key_release_o
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;

  // Key index layout: idx = {col[1:0], row[1:0]}, i.e. snapshot bit 4c+r.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case ({idx[1:0], idx[3:2]})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]      row_meta_q, row_sync_q;
  logic            active_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      col_q;
  logic [3:0]      col_n_q;
  logic [15:0]     snap_q;
  logic            col_last, eval;
  logic [3:0]      pressed_now;
  logic [15:0]     snap_full;
  logic [4:0]      key_cnt;
  logic [3:0]      key_idx;
  logic            is_none, is_single, has_cand;

  state_e          state_q;
  logic [3:0]      cand_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      key_row_q, key_col_q, key_code_q;
  logic            valid_q, press_q, release_q;

  // Two-flop synchroniser for the asynchronous, pulled-up row lines.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_n_i;
      row_sync_q <= row_meta_q;
    end
  end

  assign col_last    = active_q && (div_q == DivLast);
  assign eval        = col_last && (col_q == 2'd3);
  assign pressed_now = ~row_sync_q;

  // Column scan; all columns stay released during reset, column 0 starts on the
  // first clock afterwards so it gets a full SCAN_DIV window.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_q <= 1'b0;
      div_q    <= '0;
      col_q    <= 2'd0;
      col_n_q  <= 4'hF;
    end else if (!active_q) begin
      active_q <= 1'b1;
      col_n_q  <= 4'b1110;
    end else if (col_last) begin
      div_q   <= '0;
      col_q   <= col_q + 2'd1;
      col_n_q <= ~(4'b0001 << (col_q + 2'd1));
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Capture the settled rows at the end of each column window.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap_q <= '0;
    end else if (col_last) begin
      snap_q[{col_q, 2'b00} +: 4] <= pressed_now;
    end
  end

  // Full sweep view on the evaluation cycle: column 3 comes straight from the sync.
  always_comb begin
    snap_full        = snap_q;
    snap_full[15:12] = pressed_now;
  end

  // Classify the sweep snapshot as none / single / multi.
  always_comb begin
    key_cnt = '0;
    key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_full[i]) begin
        key_cnt = key_cnt + 5'd1;
        key_idx = 4'(i);
      end
    end
  end

  assign is_none   = (key_cnt == 5'd0);
  assign is_single = (key_cnt == 5'd1);
  assign has_cand  = snap_full[cand_q];

  // Debounce FSM with registered outputs; advances only on sweep evaluation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cand_q     <= '0;
      cnt_q      <= '0;
      key_row_q  <= '0;
      key_col_q  <= '0;
      key_code_q <= '0;
      valid_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (eval) begin
        unique case (state_q)
          StIdle: begin
            if (is_single) begin
              state_q <= StPressDb;
              cand_q  <= key_idx;
              cnt_q   <= CntW'(1);
            end
          end
          StPressDb: begin
            if (!is_single) begin
              state_q <= StIdle;
            end else if (key_idx != cand_q) begin
              cand_q <= key_idx;
              cnt_q  <= CntW'(1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q + 1'b1 == CntDone) begin
                state_q    <= StHeld;
                key_row_q  <= 4'b0001 << cand_q[1:0];
                key_col_q  <= 4'b0001 << cand_q[3:2];
                key_code_q <= key_code(cand_q);
                valid_q    <= 1'b1;
                press_q    <= 1'b1;
              end
            end
          end
          StHeld: begin
            // Any other key pattern keeps the held key; a new key needs a release first.
            if (is_none) begin
              state_q <= StReleaseDb;
              cnt_q   <= CntW'(1);
            end
          end
          StReleaseDb: begin
            if (is_none) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q + 1'b1 == CntDone) begin
                state_q   <= StIdle;
                valid_q   <= 1'b0;
                release_q <= 1'b1;
              end
            end else if (has_cand) begin
              state_q <= StHeld;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign col_n_o       = col_n_q;
  assign key_row_o     = key_row_q;
  assign key_col_o     = key_col_q;
  assign key_code_o    = key_code_q;
  assign key_valid_o   = valid_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model pulls row r low while column c is driven low and key (r,c) is held.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_row, key_col, key_code;
  logic       key_valid, key_press, key_release;
  logic [15:0] pressed = '0;  // bit 4c+r

  int tests = 0;
  int failed = 0;

  localparam logic [15:0] K1 = 16'h0001;  // r0 c0
  localparam logic [15:0] K2 = 16'h0010;  // r0 c1
  localparam logic [15:0] K5 = 16'h0020;  // r1 c1
  localparam logic [15:0] K9 = 16'h0400;  // r2 c2
  localparam logic [15:0] KE = 16'h0008;  // r3 c0
  localparam logic [15:0] KA = 16'h1000;  // r0 c3

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .row_n_i      (row_n),
    .col_n_o      (col_n),
    .key_row_o    (key_row),
    .key_col_o    (key_col),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_press_o  (key_press),
    .key_release_o(key_release)
  );

  always #5 clk = ~clk;

  // Keypad switch matrix model.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[4*c+r] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_key(input string tag, input logic [3:0] row, input logic [3:0] col,
                           input logic [3:0] code, input logic valid);
    check({tag, "_row"}, 16'(key_row), 16'(row));
    check({tag, "_col"}, 16'(key_col), 16'(col));
    check({tag, "_code"}, 16'(key_code), 16'(code));
    check({tag, "_valid"}, 16'(key_valid), 16'(valid));
  endtask

  // One full sweep (16 cycles) with the given keys held; strobes expected only on the
  // cycle right after the evaluation edge, which is the last sample of the sweep.
  task automatic sweep(input logic [15:0] keys, input logic exp_p, input logic exp_r);
    logic [3:0] exp_col;
    pressed = keys;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << (((i + 1) / 4) % 4));
      check("col_n", 16'(col_n), 16'(exp_col));
      check("press", 16'(key_press), (i == 15) ? 16'(exp_p) : 16'h0);
      check("release", 16'(key_release), (i == 15) ? 16'(exp_r) : 16'h0);
    end
  endtask

  // Release reset after a negedge; column 0 appears on the first clock.
  task automatic leave_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("col_n_pre", 16'(col_n), 16'hF);
    @(posedge clk);
    @(negedge clk);
    check("col_n_first", 16'(col_n), 16'(4'b1110));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // T1 reset and scan order
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_n", 16'(col_n), 16'hF);
    check_key("rst", 4'h0, 4'h0, 4'h0, 1'b0);
    check("rst_press", 16'(key_press), 16'h0);
    check("rst_release", 16'(key_release), 16'h0);
    leave_reset();
    sweep('0, 1'b0, 1'b0);

    // T2 press '5', held five sweeps
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b1, 1'b0);
    check_key("t2", 4'b0010, 4'b0010, 4'h5, 1'b1);
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    check_key("t2_hold", 4'b0010, 4'b0010, 4'h5, 1'b1);

    // T4 release with a one-sweep gap first
    sweep('0, 1'b0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    check_key("t4_gap", 4'b0010, 4'b0010, 4'h5, 1'b1);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b1);
    check_key("t4", 4'b0010, 4'b0010, 4'h5, 1'b0);

    // T3 bouncing '9'
    sweep(K9, 1'b0, 1'b0);
    sweep(K9, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep(K9, 1'b0, 1'b0);
    sweep(K9, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    check_key("t3", 4'b0010, 4'b0010, 4'h5, 1'b0);

    // T5 second key while held, then multi-key from idle
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b1, 1'b0);
    sweep(K5 | K1, 1'b0, 1'b0);
    sweep(K5 | K1, 1'b0, 1'b0);
    check_key("t5_both", 4'b0010, 4'b0010, 4'h5, 1'b1);
    sweep(K1, 1'b0, 1'b0);
    sweep(K1, 1'b0, 1'b0);
    check_key("t5_other", 4'b0010, 4'b0010, 4'h5, 1'b1);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b1);
    sweep(K1 | K2, 1'b0, 1'b0);
    sweep(K1 | K2, 1'b0, 1'b0);
    sweep(K1 | K2, 1'b0, 1'b0);
    sweep(K1 | K2, 1'b0, 1'b0);
    check_key("t5_multi", 4'b0010, 4'b0010, 4'h5, 1'b0);

    // T6 reset while held
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_col_n", 16'(col_n), 16'hF);
    check_key("t6_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    check("t6_release", 16'(key_release), 16'h0);
    pressed = '0;
    repeat (2) @(negedge clk);
    leave_reset();
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    check_key("t6_idle", 4'h0, 4'h0, 4'h0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b0, 1'b0);
    sweep(K5, 1'b1, 1'b0);
    check_key("t6_again", 4'b0010, 4'b0010, 4'h5, 1'b1);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b1);

    // Code map corners and candidate change during press debounce
    sweep(KE, 1'b0, 1'b0);
    sweep(KE, 1'b0, 1'b0);
    sweep(KE, 1'b1, 1'b0);
    check_key("key_e", 4'b1000, 4'b0001, 4'hE, 1'b1);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b1);
    sweep(KA, 1'b0, 1'b0);
    sweep(KA, 1'b0, 1'b0);
    sweep(KA, 1'b1, 1'b0);
    check_key("key_a", 4'b0001, 4'b1000, 4'hA, 1'b1);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b0);
    sweep('0, 1'b0, 1'b1);
    sweep(K1, 1'b0, 1'b0);
    sweep(K2, 1'b0, 1'b0);
    sweep(K2, 1'b0, 1'b0);
    sweep(K2, 1'b1, 1'b0);
    check_key("key_2", 4'b0001, 4'b0010, 4'h2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
